piso_shift_tx: RTL and testbench
================================

# piso_shift_tx

Parallel-in serial-out transmitter that sends a WIDTH-bit word one bit at a time over a single data line. It is the transmit end of the serial register chain: the receiving side is built from cascaded D flip-flops that sample SDO. The block has a valid/ready load port, a programmable bit period and frame and done strobes, so the receiver can frame the word without extra logic.

## Interface
- WIDTH, 8: word length in bits; must be at least 2.
- DIV, 1: clock cycles per transmitted bit; must be at least 1.
- MSB_FIRST, 1: 1 sends DATA[WIDTH-1] first; 0 sends DATA[0] first.
- IDLE_LEVEL, 1'b0: level driven on SDO while not transmitting.
- CLK  input  1  single clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- DATA  input  WIDTH  word to send; sampled only on an accepted load.
- LOAD_VALID  input  1  DATA is valid this cycle.
- LOAD_READY  output  1  block can accept a word; high exactly when the FSM is in IDLE.
- SDO  output  1  serial data out, registered.
- FRAME  output  1  high while a word is on SDO, registered.
- BIT_STB  output  1  one-cycle pulse in the first cycle of each bit, registered.
- DONE  output  1  one-cycle pulse after the last bit, registered.

## Operation
- Reset values: FSM=IDLE, SDO=IDLE_LEVEL, FRAME=0, BIT_STB=0, DONE=0, LOAD_READY=1, counters=0.
- States:
  - IDLE: waits for a load.
  - SHIFT: sends bits.
- IDLE→SHIFT on a rising edge with LOAD_VALID&&LOAD_READY:
  - shift register loads DATA;
  - SDO gets the first bit;
  - FRAME=1, BIT_STB=1;
  - bit counter=WIDTH-1, divide counter=DIV-1.
- In SHIFT:
  - The divide counter decrements every cycle.
  - When it reaches 0 and the bit counter is nonzero: shift the register, present the next bit on SDO, pulse BIT_STB, decrement the bit counter, reload the divide counter with DIV-1.
  - When both counters are 0 (last bit has run its full period): go to IDLE with SDO=IDLE_LEVEL, FRAME=0, DONE=1.
- BIT_STB is 0 in every cycle other than the first cycle of a bit.
- DONE is high only in the first IDLE cycle after a frame.
- Loads are ignored while LOAD_READY=0. DATA changing during SHIFT has no effect.
- Shift direction:
  - MSB_FIRST=1: shift left, SDO = register MSB.
  - MSB_FIRST=0: shift right, SDO = register LSB.
- Counter widths: the bit counter is $clog2(WIDTH), the divide counter is max(1,$clog2(DIV)). Neither counter wraps: each is reloaded before it underflows.

## Timing
- Accept at edge k. Bit i (0-based) is on SDO from edge k+i·DIV up to edge k+(i+1)·DIV.
- At edge k+WIDTH·DIV: FRAME falls, DONE rises, LOAD_READY rises.
- Frame length: WIDTH·DIV cycles with FRAME high.
- Back-to-back: LOAD_VALID held high in the DONE cycle is accepted at the next edge. The minimum gap between frames is therefore exactly one idle cycle, during which DONE=1.
- RST asserted mid-frame:
  - all outputs return to their reset values immediately, without waiting for a clock edge;
  - the word in flight is discarded;
  - DONE does not pulse.
- RST deasserted with LOAD_VALID already high: the load is accepted at the first rising edge with RST low.
- DIV=1: BIT_STB stays high for the whole of the frame.

## Structure
- Shared package: FSM state encodings (IDLE=1'b0, SHIFT=1'b1) and the default IDLE_LEVEL constant. The receive-side chain uses the same constants.
- One natural sub-module, bit_rate_div: a down-counter that generates the end-of-bit tick.
  - Inputs: CLK, RST, a restart signal.
  - Output: the tick.
- The FSM, shift register and bit counter stay in the top-level module.

## Test plan
- WIDTH=8, DIV=1, MSB_FIRST=1, load 8'hA5 at edge 0 → SDO=1,0,1,0,0,1,0,1 on edges 0–7; BIT_STB high on edges 0–7; FRAME and DONE change at edge 8 (FRAME falls, DONE pulses for one cycle); LOAD_READY=0 on edges 0–7.
- MSB_FIRST=0, DIV=1, load 8'h1E → SDO=0,1,1,1,1,0,0,0.
- DIV=3, load 8'h80, MSB_FIRST=1 → SDO=1 for 3 cycles, then 0 for 21 cycles; BIT_STB fires 8 times, 3 cycles apart; DONE at edge 24.
- LOAD_VALID held high continuously with words 8'h01 then 8'hFF → the second frame starts exactly one cycle after the first ends, and DONE is high during that gap. A third word presented during SHIFT is not accepted until LOAD_READY=1.
- RST pulsed at edge 4 of a DIV=1 frame → SDO returns to IDLE_LEVEL and FRAME to 0 without a clock edge; DONE is never asserted; the next load after RST falls transmits correctly.
- IDLE_LEVEL=1 → SDO=1 out of reset and between frames.

Source files
------------

// File: rtl/piso_shift_tx_pkg.sv
// Shared constants for the serial register chain: FSM encodings and default
// line idle level, also used by the receive side.
package piso_shift_tx_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam logic IDLE_LEVEL_DEFAULT = 1'b0;

endpackage

// File: rtl/piso_shift_tx_if.sv
// Load handshake and serial output bundle of the PISO transmitter.
interface piso_shift_tx_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] data;
  logic             load_valid;
  logic             load_ready;
  logic             sdo;
  logic             frame;
  logic             bit_stb;
  logic             done;

  modport master (
    output data,
    output load_valid,
    input  load_ready,
    input  sdo,
    input  frame,
    input  bit_stb,
    input  done
  );

  modport slave (
    input  data,
    input  load_valid,
    output load_ready,
    output sdo,
    output frame,
    output bit_stb,
    output done
  );

endinterface

// File: rtl/piso_shift_tx_bit_rate_div.sv
// Bit-period down-counter: tick is high in the last cycle of every bit period.
module bit_rate_div #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int            CW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Parks at zero when not restarted, so it never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter with valid/ready load, programmable bit
// period and registered frame / bit-strobe / done outputs.
module piso_shift_tx
  import piso_shift_tx_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter int   DIV        = 1,
  parameter int   MSB_FIRST  = 1,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
  input logic             clk,
  input logic             rst,
  piso_shift_tx_if.slave  bus
);

  localparam int            BW       = $clog2(WIDTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             sdo_q, sdo_d;
  logic             frame_q, frame_d;
  logic             bit_stb_q, bit_stb_d;
  logic             done_q, done_d;
  logic             restart;
  logic             tick;

  bit_rate_div #(
    .DIV (DIV)
  ) u_bit_rate_div (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    sdo_d     = sdo_q;
    frame_d   = frame_q;
    bit_stb_d = 1'b0;
    done_d    = 1'b0;
    restart   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.load_valid) begin
          state_d   = ST_SHIFT;
          shreg_d   = bus.data;
          sdo_d     = (MSB_FIRST != 0) ? bus.data[WIDTH-1] : bus.data[0];
          frame_d   = 1'b1;
          bit_stb_d = 1'b1;
          bit_cnt_d = BIT_LAST;
          restart   = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (bit_cnt_q != '0) begin
            // SDO is taken from the bit that becomes the head after the shift.
            if (MSB_FIRST != 0) begin
              shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
              sdo_d   = shreg_q[WIDTH-2];
            end else begin
              shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
              sdo_d   = shreg_q[1];
            end
            bit_stb_d = 1'b1;
            bit_cnt_d = bit_cnt_q - BW'(1);
            restart   = 1'b1;
          end else begin
            state_d = ST_IDLE;
            sdo_d   = IDLE_LEVEL;
            frame_d = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      sdo_q     <= IDLE_LEVEL;
      frame_q   <= 1'b0;
      bit_stb_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      sdo_q     <= sdo_d;
      frame_q   <= frame_d;
      bit_stb_q <= bit_stb_d;
      done_q    <= done_d;
    end
  end

  assign bus.load_ready = (state_q == ST_IDLE);
  assign bus.sdo        = sdo_q;
  assign bus.frame      = frame_q;
  assign bus.bit_stb    = bit_stb_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: three parameter sets checked every cycle against a
// timing model built from "bit i occupies cycles i*DIV .. (i+1)*DIV-1 of the frame".
module tb_piso_shift_tx;

  localparam int W  = 8;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  piso_shift_tx_if #(.WIDTH(W)) if0 ();
  piso_shift_tx_if #(.WIDTH(W)) if1 ();
  piso_shift_tx_if #(.WIDTH(W)) if2 ();

  piso_shift_tx #(.WIDTH(W), .DIV(1), .MSB_FIRST(1), .IDLE_LEVEL(1'b0))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  piso_shift_tx #(.WIDTH(W), .DIV(1), .MSB_FIRST(0), .IDLE_LEVEL(1'b1))
    dut1 (.clk(clk), .rst(rst), .bus(if1));
  piso_shift_tx #(.WIDTH(W), .DIV(3), .MSB_FIRST(1), .IDLE_LEVEL(1'b0))
    dut2 (.clk(clk), .rst(rst), .bus(if2));

  function automatic int div_of(input int i);
    return (i == 2) ? 3 : 1;
  endfunction
  function automatic bit msb_of(input int i);
    return (i != 1);
  endfunction
  function automatic bit idle_of(input int i);
    return (i == 1);
  endfunction

  logic [NI-1:0] vld_r;
  logic [W-1:0]  dat_r [NI];
  logic [NI-1:0] sdo_w, frame_w, stb_w, done_w, rdy_w;

  assign if0.load_valid = vld_r[0];
  assign if1.load_valid = vld_r[1];
  assign if2.load_valid = vld_r[2];
  assign if0.data = dat_r[0];
  assign if1.data = dat_r[1];
  assign if2.data = dat_r[2];
  assign sdo_w   = {if2.sdo, if1.sdo, if0.sdo};
  assign frame_w = {if2.frame, if1.frame, if0.frame};
  assign stb_w   = {if2.bit_stb, if1.bit_stb, if0.bit_stb};
  assign done_w  = {if2.done, if1.done, if0.done};
  assign rdy_w   = {if2.load_ready, if1.load_ready, if0.load_ready};

  // Reference model: per instance, whether a frame is running, the cycle
  // offset into it, the captured word and the pending DONE.
  bit         busy_m [NI];
  int         t_m    [NI];
  logic [W-1:0] word_m [NI];
  bit         done_m [NI];

  logic [W-1:0] dir_words [5] = '{8'hA5, 8'h1E, 8'h80, 8'h01, 8'hFF};
  int           qi [NI];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      busy_m[i] = 1'b0;
      done_m[i] = 1'b0;
      t_m[i]    = 0;
    end
  endtask

  task automatic model_step(input int mode);
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        busy_m[i] = 1'b0;
        done_m[i] = 1'b0;
      end else if (busy_m[i]) begin
        t_m[i]++;
        if (t_m[i] == W * div_of(i)) begin
          busy_m[i] = 1'b0;
          done_m[i] = 1'b1;
        end
      end else begin
        done_m[i] = 1'b0;
        if (vld_r[i]) begin
          busy_m[i] = 1'b1;
          t_m[i]    = 0;
          word_m[i] = dat_r[i];
          if (mode == 0) qi[i]++;
        end
      end
    end
  endtask

  task automatic check_outputs(input string ph);
    for (int i = 0; i < NI; i++) begin
      logic e_sdo, e_frame, e_stb, e_done, e_rdy;
      int   b;
      if (busy_m[i]) begin
        b       = t_m[i] / div_of(i);
        e_sdo   = msb_of(i) ? word_m[i][W-1-b] : word_m[i][b];
        e_frame = 1'b1;
        e_stb   = ((t_m[i] % div_of(i)) == 0);
        e_done  = 1'b0;
        e_rdy   = 1'b0;
      end else begin
        e_sdo   = idle_of(i);
        e_frame = 1'b0;
        e_stb   = 1'b0;
        e_done  = done_m[i];
        e_rdy   = 1'b1;
      end
      check_eq($sformatf("%s.u%0d.sdo", ph, i), 32'(sdo_w[i]), 32'(e_sdo));
      check_eq($sformatf("%s.u%0d.frame", ph, i), 32'(frame_w[i]), 32'(e_frame));
      check_eq($sformatf("%s.u%0d.bit_stb", ph, i), 32'(stb_w[i]), 32'(e_stb));
      check_eq($sformatf("%s.u%0d.done", ph, i), 32'(done_w[i]), 32'(e_done));
      check_eq($sformatf("%s.u%0d.load_ready", ph, i), 32'(rdy_w[i]), 32'(e_rdy));
    end
  endtask

  // mode 0: directed word list with valid held; 1: random; 2: valid with 8'hC3; 3: idle
  task automatic drive(input int mode);
    for (int i = 0; i < NI; i++) begin
      case (mode)
        0: begin
          vld_r[i] = (qi[i] < 5);
          dat_r[i] = (qi[i] < 5) ? dir_words[qi[i]] : W'($urandom);
        end
        1: begin
          vld_r[i] = ($urandom_range(0, 2) == 0);
          dat_r[i] = W'($urandom);
        end
        2: begin
          vld_r[i] = 1'b1;
          dat_r[i] = 8'hC3;
        end
        default: begin
          vld_r[i] = 1'b0;
          dat_r[i] = W'($urandom);
        end
      endcase
    end
  endtask

  task automatic cycle(input int mode, input string ph);
    drive(mode);
    @(posedge clk);
    model_step(mode);
    @(negedge clk);
    check_outputs(ph);
  endtask

  initial begin
    rst   = 1'b1;
    vld_r = '0;
    for (int i = 0; i < NI; i++) begin
      dat_r[i] = '0;
      qi[i]    = 0;
    end
    model_reset();
    @(negedge clk);
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    repeat (140) cycle(0, "directed");
    repeat (600) cycle(1, "random");
    repeat (30)  cycle(3, "drain");

    // Mid-frame asynchronous reset, released with a load already pending.
    cycle(2, "rst_load");
    repeat (3) cycle(3, "rst_frame");
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    drive(2);
    @(posedge clk);
    model_step(2);
    @(negedge clk);
    check_outputs("rst_hold");
    rst = 1'b0;
    cycle(2, "rst_release");
    repeat (30) cycle(3, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
